secded_decode_pipe: RTL and testbench

- Receive-side SECDED (39,32) Hamming decoder for register-file and data-path words that carry injected or real bit errors.
- Sits between the encoded operand source and the ALU/store path.
- Corrects single-bit errors and flags double-bit errors.
- Two-stage valid/ready pipeline with full backpressure and an optional error statistics block.

---
 rtl/secded_decode_pipe_if.sv | 28 ++
 rtl/secded_decode_pipe.sv | 154 +++++++++++++++
 tb/tb_secded_decode_pipe.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_decode_pipe_if.sv
// Valid/ready bundle for the SECDED decoder: codeword in, corrected word out.
// master = codeword source and result sink; slave = decoder.
interface secded_decode_pipe_if #(
  parameter int TAG_W = 5
);
  // A word moves on either side only in a cycle where valid && ready are both high.
  // A raised valid and its payload stay stable until that transfer happens.
  logic             in_valid;
  logic             in_ready;
  logic [38:0]      in_code;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_sec;
  logic             out_ded;

  modport master (
    output in_valid, in_code, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sec, out_ded
  );

  modport slave (
    input  in_valid, in_code, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sec, out_ded
  );
endinterface

// File: rtl/secded_decode_pipe.sv
// Two-stage SECDED (39,32) decoder: stage 1 registers syndrome and parity, stage 2 corrects.
// Optional saturating SEC/DED statistics counters are enabled with SECDED_STATS_EN.
module secded_decode_pipe #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_in,
  secded_decode_pipe_if.slave  bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     sec_count,
  output logic [CNT_W-1:0]     ded_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [38:0]      s1_code_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [5:0]       s1_syn_q, syn_d;
  logic             s1_par_q, par_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_data_q, data_d;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_sec_q, sec_d;
  logic             s2_ded_q, ded_d;
  logic [38:0]      corr_code;

  logic             accept;
  logic             s2_load;

  // Data bits occupy every non-power-of-two Hamming position, ascending.
  function automatic logic [31:0] extract_data(input logic [38:0] cw);
    logic [31:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k[4:0]] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  always_comb begin
    syn_d = '0;
    for (int pos = 1; pos < 39; pos++) begin
      if (bus.in_code[pos]) syn_d = syn_d ^ pos[5:0];
    end
    par_d = ^bus.in_code;
  end

  // S=0 with P=1 means only cw[0] flipped, so the data needs no fix.
  always_comb begin
    corr_code = s1_code_q;
    sec_d     = 1'b0;
    ded_d     = 1'b0;
    if (s1_syn_q == 6'd0) begin
      sec_d = s1_par_q;
    end else if (!s1_par_q) begin
      ded_d = 1'b1;
    end else if (s1_syn_q <= 6'd38) begin
      corr_code = s1_code_q ^ (39'd1 << s1_syn_q);
      sec_d     = 1'b1;
    end else begin
      ded_d = 1'b1;
    end
    data_d = extract_data(corr_code);
  end

  // Stage 1 can hand over whenever stage 2 is empty or emptying this cycle.
  assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign bus.in_ready = !s1_valid_q || !s2_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s1_valid_d   = accept || (s1_valid_q && !s2_load);
  assign s2_valid_d   = s2_load || (s2_valid_q && !bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_tag_q   <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_sec_q   <= 1'b0;
      s2_ded_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_code_q <= bus.in_code;
        s1_tag_q  <= bus.in_tag;
        s1_syn_q  <= syn_d;
        s1_par_q  <= par_d;
      end
      if (s2_load) begin
        s2_data_q <= data_d;
        s2_tag_q  <= s1_tag_q;
        s2_sec_q  <= sec_d;
        s2_ded_q  <= ded_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_tag   = s2_tag_q;
  assign bus.out_sec   = s2_sec_q;
  assign bus.out_ded   = s2_ded_q;

`ifdef SECDED_STATS_EN
  logic             out_xfer;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  assign out_xfer = s2_valid_q && bus.out_ready;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_xfer) begin
      if (s2_sec_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + 1'b1;
      if (s2_ded_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign sec_count = sec_cnt_q;
  assign ded_count = ded_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_count      = '0;
  assign ded_count      = '0;
`endif

endmodule

// File: tb/tb_secded_decode_pipe.sv
// Bench for secded_decode_pipe: directed literals, backpressure, random error injection
// against a reference built from encode + injected flip count; counters follow SECDED_STATS_EN.
module tb_secded_decode_pipe;
  localparam int TAG_W = 5;
  localparam int CNT_W = 3;
  localparam int EW    = TAG_W + 34;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SECDED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_in;
  logic             cnt_clr;
  logic [CNT_W-1:0] sec_count;
  logic [CNT_W-1:0] ded_count;

  secded_decode_pipe_if #(.TAG_W(TAG_W)) bus ();

  secded_decode_pipe #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_in    (rst_in),
    .bus       (bus),
    .cnt_clr   (cnt_clr),
    .sec_count (sec_count),
    .ded_count (ded_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int emits = 0;
  int model_sec = 0;
  int model_ded = 0;
  int ready_mode = 1;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [38:0] encode(input logic [31:0] d);
    logic [38:0] cw;
    int k;
    logic p;
    cw = '0;
    k = 0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k[4:0]];
        k++;
      end
    end
    for (int j = 0; j < 6; j++) begin
      p = 1'b0;
      for (int pos = 1; pos < 39; pos++)
        if (((pos >> j) & 1) == 1 && pos != (1 << j)) p = p ^ cw[pos];
      cw[1 << j] = p;
    end
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic logic [31:0] extract(input logic [38:0] cw);
    logic [31:0] d;
    int k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < 39; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k[4:0]] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [EW-1:0] pack(input logic [TAG_W-1:0] tag, input logic sec,
                                         input logic ded, input logic [31:0] d);
    return {tag, sec, ded, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [38:0] code, input logic [TAG_W-1:0] tag, input logic [EW-1:0] e);
    int n;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for tag %0h", tag);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_random(input logic [TAG_W-1:0] tag, input int nf);
    logic [31:0] d;
    logic [38:0] code;
    int p1, p2;
    d = $urandom;
    code = encode(d);
    p1 = $urandom_range(0, 38);
    do p2 = $urandom_range(0, 38); while (p2 == p1);
    if (nf >= 1) code[p1] = ~code[p1];
    if (nf == 2) code[p2] = ~code[p2];
    if (nf == 0)      send(code, tag, pack(tag, 1'b0, 1'b0, d));
    else if (nf == 1) send(code, tag, pack(tag, 1'b1, 1'b0, d));
    else              send(code, tag, pack(tag, 1'b0, 1'b1, extract(code)));
  endtask

  // Downstream ready: forced low, forced high, or random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic          hold_v = 1'b0;
  logic [EW-1:0] hold_p;

  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    if (rst_in) begin
      exp_q.delete();
      model_sec = 0;
      model_ded = 0;
      hold_v    = 1'b0;
    end else begin
      got = {bus.out_tag, bus.out_sec, bus.out_ded, bus.out_data};
      check("sec_count", 64'(sec_count), STATS ? 64'(model_sec) : 64'd0);
      check("ded_count", 64'(ded_count), STATS ? 64'(model_ded) : 64'd0);
      if (hold_v) check("hold_stable", {bus.out_valid, got}, {1'b1, hold_p});
      if (bus.in_valid && bus.in_ready) accepts++;
      if (bus.out_valid && bus.out_ready) begin
        emits++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got word %0h, expected none", got);
        end else begin
          e = exp_q.pop_front();
          check("out_word", got, e);
          if (e[33] && model_sec < CMAX) model_sec++;
          if (e[32] && model_ded < CMAX) model_ded++;
        end
      end
      if (cnt_clr) begin
        model_sec = 0;
        model_ded = 0;
      end
      hold_v = bus.out_valid && !bus.out_ready;
      hold_p = got;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst_in       = 1'b1;
    cnt_clr      = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = 39'h000000000F;
    bus.in_tag   = 5'h1F;
    repeat (2) @(posedge clk);
    #1;
    rst_in       = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_sec_count", 64'(sec_count), 64'd0);
    check("rst_ded_count", 64'(ded_count), 64'd0);
    @(negedge clk);
    check("rst_no_ghost", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    check("model_enc_1", 64'(encode(32'h1)), 64'h0F);
    check("model_enc_0", 64'(encode(32'h0)), 64'h0);
    check("model_extract_28", 64'(extract(39'h0000000028)), 64'h3);

    // Latency on an empty pipeline: visible after the second edge from accept.
    send(39'h000000000F, 5'h01, pack(5'h01, 1'b0, 1'b0, 32'h1));
    @(negedge clk);
    check("lat_not_yet", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("lat_data", 64'(bus.out_data), 64'h1);
    check("lat_tag", 64'(bus.out_tag), 64'h1);
    @(posedge clk);
    #1;

    send(39'h0000000007, 5'h02, pack(5'h02, 1'b1, 1'b0, 32'h1));
    send(39'h000000000E, 5'h03, pack(5'h03, 1'b1, 1'b0, 32'h1));
    send(39'h0000000028, 5'h04, pack(5'h04, 1'b0, 1'b1, 32'h3));
    send(39'h0100000081, 5'h05, pack(5'h05, 1'b0, 1'b1, 32'h8));
    drain();
    @(negedge clk);
    check("dir_sec_count", 64'(sec_count), STATS ? 64'd2 : 64'd0);
    check("dir_ded_count", 64'(ded_count), STATS ? 64'd2 : 64'd0);
    @(posedge clk);
    #1;

    // Backpressure: two accepts fill both stages, then in_ready drops.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    base = accepts;
    fork
      begin
        for (int i = 0; i < 4; i++) send_random(5'(10 + i), i % 3);
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_accepts", 64'(accepts - base), 64'd2);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        ready_mode = 1;
      end
    join
    drain();

    // Random traffic with random gaps and random downstream stalls.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_random(5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end
    ready_mode = 1;
    drain();

    // Clear held across an error transfer wins over the increment.
    cnt_clr = 1'b1;
    send_random(5'h1A, 1);
    send_random(5'h1B, 2);
    drain();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_sec_count", 64'(sec_count), 64'd0);
    check("clr_ded_count", 64'(ded_count), 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < CMAX + 2; i++) send_random(5'(i), 1);
    for (int i = 0; i < CMAX + 2; i++) send_random(5'(i), 2);
    drain();
    @(negedge clk);
    check("sat_sec_count", 64'(sec_count), STATS ? 64'(CMAX) : 64'd0);
    check("sat_ded_count", 64'(ded_count), STATS ? 64'(CMAX) : 64'd0);
    check("all_emitted", 64'(emits), 64'(accepts));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
